// File: rtl/fpga_puf_pkg.sv
// Shared types and default widths for the PUF challenge sequencer slice.
package fpga_puf_pkg;

  localparam int DEF_CHAL_WIDTH      = 64;
  localparam int DEF_LEN_WIDTH       = 32;
  localparam int DEF_MAX_OUTSTANDING = 8;
  localparam int DEF_OUT_WIDTH       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/fpga_puf_counter.sv
// Generic up/down counter with parallel load; load wins, incr+decr together cancel.
module fpga_puf_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         incr,
  input  logic         decr,
  output logic [W-1:0] count,
  output logic         is_zero
);

  // Count register update
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= {W{1'b0}};
    end else if (load) begin
      count <= load_val;
    end else if (incr && !decr) begin
      count <= count + W'(1);
    end else if (decr && !incr) begin
      count <= count - W'(1);
    end else begin
      count <= count;
    end
  end

  assign is_zero = (count == {W{1'b0}});

endmodule

// File: rtl/fpga_puf_challenge_sequencer.sv
// Issues a burst of consecutive PUF challenges, bounds outstanding ones and
// pulses done once every response has been accepted.
module fpga_puf_challenge_sequencer
  import fpga_puf_pkg::*;
#(
  parameter int C_CHAL_WIDTH      = DEF_CHAL_WIDTH,
  parameter int C_LEN_WIDTH       = DEF_LEN_WIDTH,
  parameter int C_MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int C_OUT_WIDTH       = DEF_OUT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [C_CHAL_WIDTH-1:0] base_challenge,
  input  logic [C_LEN_WIDTH-1:0]  num_challenges,
  output logic                    busy,
  output logic                    done,
  output logic                    chal_valid,
  input  logic                    chal_ready,
  output logic [C_CHAL_WIDTH-1:0] chal_data,
  input  logic                    resp_valid,
  output logic                    resp_ready,
  output logic [C_OUT_WIDTH-1:0]  outstanding
);

  seq_state_t              state_r;
  logic [C_CHAL_WIDTH-1:0] next_chal_r;
  logic [C_CHAL_WIDTH-1:0] present_data_s;
  logic [C_LEN_WIDTH-1:0]  issue_rem_s;
  logic [C_LEN_WIDTH-1:0]  resp_rem_s;
  logic [C_LEN_WIDTH-1:0]  issue_load_val_s;
  logic issue_zero_s, resp_zero_s, out_zero_s;
  logic start_ok_s, num_zero_s, resp_acc_s, slot_free_s, present_s;
  logic out_decr_s, resp_next_zero_s, issue_fin_s;

  assign start_ok_s  = (state_r == IDLE) && start;
  assign num_zero_s  = (num_challenges == {C_LEN_WIDTH{1'b0}});
  assign resp_acc_s  = resp_valid && resp_ready;
  // A response retiring in this cycle frees its slot for a same-edge presentation
  assign slot_free_s = (outstanding < C_OUT_WIDTH'(C_MAX_OUTSTANDING)) || resp_acc_s;
  // The start edge itself presents the first challenge so it is visible one cycle later
  assign present_s   = (start_ok_s && !num_zero_s) ||
                       ((state_r == ISSUE) && (!chal_valid || chal_ready) &&
                        (issue_rem_s != {C_LEN_WIDTH{1'b0}}) && slot_free_s);
  assign present_data_s   = (state_r == IDLE) ? base_challenge : next_chal_r;
  assign issue_load_val_s = num_zero_s ? {C_LEN_WIDTH{1'b0}} : (num_challenges - C_LEN_WIDTH'(1));
  assign out_decr_s       = resp_acc_s && !out_zero_s;
  assign issue_fin_s      = issue_zero_s && (!chal_valid || chal_ready);
  assign resp_next_zero_s = start_ok_s ? num_zero_s :
                            (resp_acc_s ? (resp_rem_s == C_LEN_WIDTH'(1)) : resp_zero_s);

  fpga_puf_counter #(.W(C_LEN_WIDTH)) u_issue_cnt (
    .clk(clk), .rst(rst), .load(start_ok_s), .load_val(issue_load_val_s),
    .incr(1'b0), .decr(present_s), .count(issue_rem_s), .is_zero(issue_zero_s)
  );

  fpga_puf_counter #(.W(C_LEN_WIDTH)) u_resp_cnt (
    .clk(clk), .rst(rst), .load(start_ok_s), .load_val(num_challenges),
    .incr(1'b0), .decr(resp_acc_s), .count(resp_rem_s), .is_zero(resp_zero_s)
  );

  fpga_puf_counter #(.W(C_OUT_WIDTH)) u_out_cnt (
    .clk(clk), .rst(rst), .load(1'b0), .load_val({C_OUT_WIDTH{1'b0}}),
    .incr(present_s), .decr(out_decr_s), .count(outstanding), .is_zero(out_zero_s)
  );

  // Sequencer FSM, challenge stream register and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      chal_valid  <= 1'b0;
      chal_data   <= {C_CHAL_WIDTH{1'b0}};
      next_chal_r <= {C_CHAL_WIDTH{1'b0}};
      resp_ready  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (present_s) begin
        chal_valid  <= 1'b1;
        chal_data   <= present_data_s;
        next_chal_r <= present_data_s + C_CHAL_WIDTH'(1);
      end else if (chal_valid && chal_ready) begin
        chal_valid <= 1'b0;
      end else begin
        chal_valid <= chal_valid;
      end
      case (state_r)
        IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            resp_ready <= !num_zero_s;
            if (num_zero_s) begin
              state_r <= DONE;
              done    <= 1'b1;
            end else begin
              state_r <= ISSUE;
            end
          end else begin
            busy       <= 1'b0;
            resp_ready <= 1'b0;
          end
        end
        ISSUE: begin
          resp_ready <= !resp_next_zero_s;
          if (issue_fin_s) begin
            if (resp_next_zero_s) begin
              state_r <= DONE;
              done    <= 1'b1;
            end else begin
              state_r <= DRAIN;
            end
          end else begin
            state_r <= ISSUE;
          end
        end
        DRAIN: begin
          resp_ready <= !resp_next_zero_s;
          if (resp_next_zero_s) begin
            state_r <= DONE;
            done    <= 1'b1;
          end else begin
            state_r <= DRAIN;
          end
        end
        DONE: begin
          state_r    <= IDLE;
          busy       <= 1'b0;
          resp_ready <= 1'b0;
        end
        default: begin
          state_r    <= IDLE;
          busy       <= 1'b0;
          chal_valid <= 1'b0;
          resp_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_puf_challenge_sequencer.sv
// Scoreboard bench: expected challenges queued at start, compared on each handshake.
module tb_fpga_puf_challenge_sequencer;

  localparam int CW = 64;
  localparam int LW = 32;
  localparam int OW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, chal_ready = 1'b0, resp_valid = 1'b0;
  logic [CW-1:0] base = '0;
  logic [LW-1:0] num = '0;
  logic          busy, done, chal_valid, resp_ready;
  logic [CW-1:0] chal_data;
  logic [OW-1:0] outstanding;

  logic          start_b = 1'b0, chal_ready_b = 1'b0, resp_valid_b = 1'b0;
  logic [CW-1:0] base_b = '0;
  logic [LW-1:0] num_b = '0;
  logic          busy_b, done_b, chal_valid_b, resp_ready_b;
  logic [CW-1:0] chal_data_b;
  logic [OW-1:0] outstanding_b;

  int tests = 0, fails = 0, cyc = 0;
  logic [CW-1:0] exp_q[$];
  int due_q[$];
  bit auto_resp = 1'b0;
  int done_cnt = 0, done_cyc = -1, last_acc_cyc = -1;
  int hs_cnt = 0, first_hs = -1, last_hs = -1;

  fpga_puf_challenge_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .base_challenge(base), .num_challenges(num),
    .busy(busy), .done(done), .chal_valid(chal_valid), .chal_ready(chal_ready),
    .chal_data(chal_data), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .outstanding(outstanding)
  );

  fpga_puf_challenge_sequencer #(.C_MAX_OUTSTANDING(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .base_challenge(base_b), .num_challenges(num_b),
    .busy(busy_b), .done(done_b), .chal_valid(chal_valid_b), .chal_ready(chal_ready_b),
    .chal_data(chal_data_b), .resp_valid(resp_valid_b), .resp_ready(resp_ready_b),
    .outstanding(outstanding_b)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // One clock: drive model responses, score the handshakes of this edge, then advance
  task automatic step();
    logic [CW-1:0] e;
    resp_valid = auto_resp && (due_q.size() > 0) && (due_q[0] <= cyc);
    if (chal_valid && chal_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL chal_unexpected got=%h expected no challenge", chal_data);
      end else begin
        e = exp_q.pop_front();
        if (chal_data !== e) begin
          fails++;
          $display("FAIL chal_data got=%h expected=%h", chal_data, e);
        end
      end
      due_q.push_back(cyc + 2);
      hs_cnt++;
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
    end
    if (resp_valid && resp_ready) begin
      due_q.delete(0);
      last_acc_cyc = cyc;
    end
    tests++;
    if (outstanding > OW'(8)) begin
      fails++;
      $display("FAIL outstanding_bound got=%0d max=8", outstanding);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic pulse_start(input logic [CW-1:0] b, input logic [LW-1:0] n);
    base = b;
    num = n;
    for (int i = 0; i < int'(n); i++) exp_q.push_back(b + CW'(i));
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input string name);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      step();
      n++;
    end
    tests++;
    if (done_cnt == d0) begin
      fails++;
      $display("FAIL %s_timeout got=no done required=done within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || chal_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl got busy=%b done=%b valid=%b required 0,0,0", busy, done, chal_valid);
    end
    tests++;
    if (chal_data !== '0 || resp_ready !== 1'b0 || outstanding !== '0) begin
      fails++;
      $display("FAIL reset_data got data=%h rready=%b out=%0d required 0,0,0", chal_data, resp_ready, outstanding);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_burst();
    int d0;
    chal_ready = 1'b1;
    auto_resp = 1'b1;
    hs_cnt = 0;
    first_hs = -1;
    d0 = done_cnt;
    pulse_start(64'h10, 32'd4);
    tests++;
    if (busy !== 1'b1 || chal_valid !== 1'b1 || chal_data !== 64'h10) begin
      fails++;
      $display("FAIL burst_first got busy=%b valid=%b data=%h required 1,1,10", busy, chal_valid, chal_data);
    end
    run_until_done(40, "burst");
    tests++;
    if (done_cyc != last_acc_cyc + 1) begin
      fails++;
      $display("FAIL burst_done_latency got=%0d required=%0d", done_cyc, last_acc_cyc + 1);
    end
    tests++;
    if (hs_cnt != 4 || last_hs - first_hs != 3) begin
      fails++;
      $display("FAIL burst_consecutive got hs=%0d span=%0d required 4,3", hs_cnt, last_hs - first_hs);
    end
    step();
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL burst_busy_drop got busy=%b done=%b required 0,0", busy, done);
    end
    step();
    tests++;
    if (done_cnt != d0 + 1 || exp_q.size() != 0 || outstanding !== '0) begin
      fails++;
      $display("FAIL burst_end got dones=%0d left=%0d out=%0d required 1,0,0", done_cnt - d0, exp_q.size(), outstanding);
    end
  endtask

  task automatic test_stall();
    chal_ready = 1'b0;
    auto_resp = 1'b1;
    pulse_start(64'h200, 32'd2);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (chal_valid !== 1'b1 || chal_data !== 64'h200 || outstanding !== 4'd1) begin
        fails++;
        $display("FAIL stall_hold got valid=%b data=%h out=%0d required 1,200,1", chal_valid, chal_data, outstanding);
      end
      step();
    end
    chal_ready = 1'b1;
    run_until_done(40, "stall");
    step();
    tests++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL stall_end got left=%0d busy=%b required 0,0", exp_q.size(), busy);
    end
  endtask

  task automatic test_wrap();
    chal_ready = 1'b1;
    auto_resp = 1'b1;
    pulse_start(64'hFFFF_FFFF_FFFF_FFFE, 32'd3);
    run_until_done(40, "wrap");
    step();
    tests++;
    if (exp_q.size() != 0 || outstanding !== '0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL wrap_end got left=%0d out=%0d busy=%b required 0,0,0", exp_q.size(), outstanding, busy);
    end
  endtask

  task automatic test_zero();
    chal_ready = 1'b1;
    pulse_start(64'h99, 32'd0);
    tests++;
    if (done !== 1'b1 || busy !== 1'b1 || chal_valid !== 1'b0 || resp_ready !== 1'b0) begin
      fails++;
      $display("FAIL zero_cycle1 got done=%b busy=%b valid=%b rready=%b required 1,1,0,0", done, busy, chal_valid, resp_ready);
    end
    step();
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || chal_valid !== 1'b0) begin
      fails++;
      $display("FAIL zero_cycle2 got done=%b busy=%b valid=%b required 0,0,0", done, busy, chal_valid);
    end
  endtask

  task automatic test_max_outstanding();
    int hs_b = 0;
    int n = 0;
    bit seen = 1'b0;
    chal_ready_b = 1'b1;
    base_b = 64'h500;
    num_b = 32'd5;
    start_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (chal_valid_b && chal_ready_b) hs_b++;
      step();
      start_b = 1'b0;
    end
    tests++;
    if (hs_b != 2 || outstanding_b !== 4'd2 || chal_valid_b !== 1'b0) begin
      fails++;
      $display("FAIL maxout_cap got hs=%0d out=%0d valid=%b required 2,2,0", hs_b, outstanding_b, chal_valid_b);
    end
    resp_valid_b = 1'b1;
    step();
    resp_valid_b = 1'b0;
    tests++;
    if (chal_valid_b !== 1'b1 || chal_data_b !== 64'h502) begin
      fails++;
      $display("FAIL maxout_release got valid=%b data=%h required 1,502", chal_valid_b, chal_data_b);
    end
    while (!seen && n < 60) begin
      resp_valid_b = (outstanding_b != '0);
      if (chal_valid_b && chal_ready_b) hs_b++;
      step();
      n++;
      seen = (done_b === 1'b1);
      tests++;
      if (outstanding_b > OW'(2)) begin
        fails++;
        $display("FAIL maxout_bound got=%0d max=2", outstanding_b);
      end
    end
    resp_valid_b = 1'b0;
    tests++;
    if (!seen || hs_b != 5) begin
      fails++;
      $display("FAIL maxout_end got done=%b hs=%0d required 1,5", seen, hs_b);
    end
    step();
  endtask

  task automatic test_reset_mid_burst();
    int d0;
    chal_ready = 1'b1;
    auto_resp = 1'b0;
    pulse_start(64'h300, 32'd6);
    step();
    step();
    tests++;
    if (outstanding !== 4'd3) begin
      fails++;
      $display("FAIL midrst_pre got out=%0d required 3", outstanding);
    end
    chal_ready = 1'b0;
    rst = 1'b1;
    d0 = done_cnt;
    step();
    rst = 1'b0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || chal_valid !== 1'b0 || chal_data !== '0 ||
        resp_ready !== 1'b0 || outstanding !== '0) begin
      fails++;
      $display("FAIL midrst_outputs got busy=%b done=%b valid=%b data=%h rready=%b out=%0d required all 0",
               busy, done, chal_valid, chal_data, resp_ready, outstanding);
    end
    exp_q.delete();
    due_q.delete();
    for (int i = 0; i < 3; i++) step();
    tests++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL midrst_nodone got dones=%0d busy=%b required 0,0", done_cnt - d0, busy);
    end
    chal_ready = 1'b1;
    auto_resp = 1'b1;
    pulse_start(64'h400, 32'd1);
    run_until_done(40, "midrst_fresh");
    step();
    tests++;
    if (exp_q.size() != 0 || outstanding !== '0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL midrst_fresh_end got left=%0d out=%0d busy=%b required 0,0,0", exp_q.size(), outstanding, busy);
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_stall();
    test_wrap();
    test_zero();
    test_max_outstanding();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fpga_puf_challenge_sequencer.md
# fpga_puf_challenge_sequencer

Sequences a burst of PUF challenges into the PUF core and tracks returned responses, so a kernel control path can request "evaluate N consecutive challenges from base B" with one start pulse. Sits between kernel control registers and the PUF core's challenge/response streams. Limits outstanding (issued, unanswered) challenges to protect the core's response FIFO. Pulses `done` once every response has been accepted.

## Interface
- C_CHAL_WIDTH, 64, challenge word width
- C_LEN_WIDTH, 32, width of challenge count
- C_MAX_OUTSTANDING, 8, max issued-but-unanswered challenges; 1..2^C_OUT_WIDTH-1
- C_OUT_WIDTH, 4, outstanding counter width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin burst; sampled only in IDLE
- base_challenge  in  C_CHAL_WIDTH  first challenge, captured on accepted start
- num_challenges  in  C_LEN_WIDTH  burst length, captured on accepted start; 0 legal
- busy  out  1  high in ISSUE/DRAIN/DONE
- done  out  1  one-cycle pulse at burst completion
- chal_valid  out  1  challenge valid
- chal_ready  in  1  PUF core accepts challenge
- chal_data  out  C_CHAL_WIDTH  current challenge
- resp_valid  in  1  PUF core has a response
- resp_ready  out  1  sequencer accepts response (payload routed elsewhere)
- outstanding  out  C_OUT_WIDTH  current outstanding count

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: `start`=1 loads issue-remaining and resp-remaining counters with `num_challenges`, next challenge register with `base_challenge`. num≠0 -> ISSUE; num=0 -> DONE. `start` outside IDLE ignored.
- ISSUE: a challenge is "presented" by registering `chal_valid`=1 with `chal_data`=next challenge. A new challenge is presented only when no challenge is pending, issue-remaining≠0 and `outstanding`<C_MAX_OUTSTANDING. Presenting increments `outstanding`, decrements issue-remaining, advances next challenge by +1 modulo 2^C_CHAL_WIDTH (wraps, no flag).
- AXI-stream rule: once `chal_valid`=1, it and `chal_data` stay stable until the cycle `chal_valid && chal_ready`; `chal_valid` falls the next cycle unless a new challenge is presented in the same edge (back-to-back allowed: one challenge per cycle at full throughput).
- ISSUE -> DRAIN when issue-remaining reaches 0 and the last challenge has handshaken.
- `resp_ready`=1 in ISSUE and DRAIN while resp-remaining≠0; each `resp_valid && resp_ready` decrements resp-remaining and `outstanding`.
- Presentation and response acceptance in the same cycle: `outstanding` unchanged.
- DRAIN -> DONE when resp-remaining reaches 0. DONE: `done`=1 for one cycle, -> IDLE.
- `resp_valid` in IDLE/DONE or with resp-remaining=0: not accepted (`resp_ready`=0), no state effect.

## Timing
- Reset values: busy=0, done=0, chal_valid=0, chal_data=0, resp_ready=0, outstanding=0, state IDLE. All outputs registered.
- Reset mid-burst: aborts immediately. No `done`. Counters cleared. In-flight responses are the PUF core's concern.
- start (cycle 0) -> busy=1 and first chal_valid=1 at cycle 1.
- Last response accepted at cycle t -> state DONE, `done`=1 at t+1 -> busy=0 at t+2. A new `start` is accepted at t+2.
- num=0: start at cycle 0 -> done=1 at cycle 1, no chal_valid.
- `outstanding` never exceeds C_MAX_OUTSTANDING and never underflows.

## Structure
- Shared package fpga_puf_pkg: state enum `seq_state_t` (IDLE, ISSUE, DRAIN, DONE), default widths.
- Sub-module: three instances of the existing `fpga_puf_counter` block. Issue-remaining and resp-remaining counters use load/decr/is_zero. The outstanding counter uses incr/decr and is reset-cleared.
- Challenge increment register and FSM live in this module.

## Test plan
- num=4, base=0x10, chal_ready=1, response 2 cycles after each handshake -> chal_data 0x10,0x11,0x12,0x13 on consecutive cycles. `done` fires once, 1 cycle after the 4th response.
- C_MAX_OUTSTANDING=2, num=5, responses withheld -> exactly 2 challenges presented and `outstanding`=2. Release one response -> the 3rd challenge is presented the next cycle.
- chal_ready held low 5 cycles while valid -> chal_valid and chal_data stable throughout. Issue count not advanced beyond 1.
- base=0xFFFF_FFFF_FFFF_FFFE, num=3 -> chal_data ...FE, ...FF, 0x0. Burst completes normally.
- num=0 -> done at cycle 1, no chal_valid, busy high for exactly 1 cycle.
- rst asserted with outstanding=3 mid-burst -> next cycle all outputs at reset values, no done. A fresh start with num=1 completes correctly.
